// File: rtl/idli_sqi_mem.sv
// idli SQI memory responder.
// Plays the memory end of one 4-bit SQI link. One command per chip-select
// assertion: 0x03 reads and 0x02 writes, both sequential from a 24-bit
// address whose low ADDR_W bits are used. Any other command is ignored
// until chip select is released.
//
// Edge-by-edge handshake (rising edge of i_clk, i_sqi_cs_n low):
//   E0-E1  command byte in, high nibble first
//   E2-E7  address in, most-significant nibble first
//   read : E8-E9 dummy; o_sqi_sio/o_sqi_oe register the first nibble at E9,
//          then one nibble per edge with the address stepping after each low
//          nibble
//   write: high nibble on even edges, byte committed on odd edges
// A rising edge with i_sqi_cs_n high ends the transaction and drops any
// half-received write byte.

package idli_sqi_mem_pkg;
  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DUMMY  = 3'd2,
    ST_RD     = 3'd3,
    ST_WR     = 3'd4,
    ST_IGNORE = 3'd5
  } sqi_state_t;
endpackage

module idli_sqi_mem
  import idli_sqi_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_sqi_cs_n,
  input  sqi_data_t i_sqi_sio,
  output sqi_data_t o_sqi_sio,
  output logic      o_sqi_oe
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Byte storage; deliberately never reset so contents survive i_rst_n.
  logic [7:0] mem_q [DEPTH];

  sqi_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;       // nibble index inside CMD/ADDR/DUMMY
  logic              phase_q, phase_d;   // 1 = next nibble is the low one
  logic              rd_q, rd_d;         // decoded command was a read
  sqi_data_t         cmd_hi_q, cmd_hi_d;
  sqi_data_t         wr_hi_q, wr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  sqi_data_t         sio_q, sio_d;
  logic              oe_q, oe_d;

  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_byte;
  logic [ADDR_W+3:0] addr_shift;
  logic [7:0]        cmd_byte;

  assign rd_byte    = mem_q[addr_q];
  assign addr_shift = {addr_q, i_sqi_sio};
  assign cmd_byte   = {cmd_hi_q, i_sqi_sio};

  // Next-state, datapath and output decode for one rising edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    rd_d      = rd_q;
    cmd_hi_d  = cmd_hi_q;
    wr_hi_d   = wr_hi_q;
    addr_d    = addr_q;
    sio_d     = sio_q;
    oe_d      = oe_q;
    mem_we    = 1'b0;
    mem_wdata = {wr_hi_q, i_sqi_sio};

    if (i_sqi_cs_n) begin
      // Deselected: back to idle, stop driving, forget partial state.
      state_d = ST_CMD;
      cnt_d   = 3'd0;
      phase_d = 1'b0;
      rd_d    = 1'b0;
      addr_d  = '0;
      sio_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_CMD: begin
          if (cnt_q == 3'd0) begin
            cmd_hi_d = i_sqi_sio;
            cnt_d    = 3'd1;
          end else begin
            cnt_d  = 3'd0;
            addr_d = '0;
            if (cmd_byte == CMD_READ) begin
              rd_d    = 1'b1;
              state_d = ST_ADDR;
            end else if (cmd_byte == CMD_WRITE) begin
              rd_d    = 1'b0;
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        ST_ADDR: begin
          // Shifting all six nibbles through keeps only the low ADDR_W bits.
          addr_d = addr_shift[ADDR_W-1:0];
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            phase_d = 1'b0;
            state_d = rd_q ? ST_DUMMY : ST_WR;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        ST_DUMMY: begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            // Second dummy edge launches the first read nibble.
            cnt_d   = 3'd0;
            state_d = ST_RD;
            sio_d   = rd_byte[7:4];
            oe_d    = 1'b1;
            phase_d = 1'b1;
          end
        end

        ST_RD: begin
          if (phase_q) begin
            sio_d   = rd_byte[3:0];
            addr_d  = addr_q + ADDR_W'(1);
            phase_d = 1'b0;
          end else begin
            sio_d   = rd_byte[7:4];
            phase_d = 1'b1;
          end
        end

        ST_WR: begin
          if (!phase_q) begin
            wr_hi_d = i_sqi_sio;
            phase_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            phase_d = 1'b0;
          end
        end

        ST_IGNORE: begin
          // Hold quiet until chip select is released.
          oe_d  = 1'b0;
          sio_d = '0;
        end

        default: begin
          state_d = ST_CMD;
          oe_d    = 1'b0;
          sio_d   = '0;
        end
      endcase
    end
  end

  // Control and output registers; async reset aborts any transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_CMD;
      cnt_q    <= 3'd0;
      phase_q  <= 1'b0;
      rd_q     <= 1'b0;
      cmd_hi_q <= '0;
      wr_hi_q  <= '0;
      addr_q   <= '0;
      sio_q    <= '0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      rd_q     <= rd_d;
      cmd_hi_q <= cmd_hi_d;
      wr_hi_q  <= wr_hi_d;
      addr_q   <= addr_d;
      sio_q    <= sio_d;
      oe_q     <= oe_d;
    end
  end

  // Byte commit on the second nibble of each write byte.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  // The data register only ever holds a value while oe is set.
  assign o_sqi_sio = oe_q ? sio_q : '0;
  assign o_sqi_oe  = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed bench for idli_sqi_mem: write, read, wrap, abort, unknown
// command and mid-read reset, checked against a byte model of the memory.
module tb_idli_sqi_mem;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n  = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       oe;

  always #5 clk = ~clk;

  idli_sqi_mem #(.ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sqi_cs_n (cs_n),
    .i_sqi_sio  (sio_i),
    .o_sqi_sio  (sio_o),
    .o_sqi_oe   (oe)
  );

  // ---------------- scoreboard ----------------
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] model_mem [DEPTH];
  logic [3:0] exp_q [$];
  logic [7:0] wbuf [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  // One bus edge with chip select low.
  task automatic nib(input logic [3:0] v);
    @(negedge clk);
    cs_n  = 1'b0;
    sio_i = v;
    @(posedge clk);
    #1;
  endtask

  // One bus edge where the responder must stay quiet.
  task automatic nib_q(input logic [3:0] v, input string tag);
    nib(v);
    check({tag, "_oe"}, 32'(oe), 32'd0);
    check({tag, "_sio"}, 32'(sio_o), 32'd0);
  endtask

  task automatic cs_idle();
    @(negedge clk);
    cs_n  = 1'b1;
    sio_i = 4'h0;
    @(posedge clk);
    #1;
    check("idle_oe", 32'(oe), 32'd0);
    check("idle_sio", 32'(sio_o), 32'd0);
  endtask

  task automatic send_addr(input logic [23:0] a, input string tag);
    for (int k = 5; k >= 0; k--) nib_q(a[k*4 +: 4], tag);
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    nib_q(4'h0, "wr_cmd");
    nib_q(4'h2, "wr_cmd");
    send_addr(a, "wr_addr");
    for (int i = 0; i < n; i++) begin
      nib_q(wbuf[i][7:4], "wr_dat");
      nib_q(wbuf[i][3:0], "wr_dat");
      model_mem[(int'(a) + i) % DEPTH] = wbuf[i];
    end
    cs_idle();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = model_mem[(int'(a) + i) % DEPTH];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    nib_q(4'h0, "rd_cmd");
    nib_q(4'h3, "rd_cmd");
    send_addr(a, "rd_addr");
    nib_q(4'h0, "rd_dummy");
    nib(4'h0);  // E9: first nibble registered here
    for (int j = 0; j < 2 * n; j++) begin
      if (j > 0) nib(4'h0);
      check("rd_oe", 32'(oe), 32'd1);
      check("rd_nib", 32'(sio_o), 32'(exp_q.pop_front()));
    end
    cs_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #23;
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_sio", 32'(sio_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cs_idle();

    // Basic write then read back across two bytes
    wbuf[0] = 8'hAB; wbuf[1] = 8'hCD;
    do_write(24'h000005, 2);
    do_read(24'h000005, 2);

    // Wrap at the top of memory, upper address bits ignored on read
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    do_write(24'h0003FF, 2);
    do_read(24'hFFF3FF, 2);

    // Abort: half byte after a completed one is discarded
    wbuf[0] = 8'h55; wbuf[1] = 8'h66;
    do_write(24'h000010, 2);
    nib_q(4'h0, "ab_cmd");
    nib_q(4'h2, "ab_cmd");
    send_addr(24'h000010, "ab_addr");
    nib_q(4'h7, "ab_dat");
    nib_q(4'h8, "ab_dat");
    nib_q(4'h9, "ab_dat");
    model_mem[16] = 8'h78;
    cs_idle();
    do_read(24'h000010, 2);

    // Unknown command: would overwrite 0x005 if it were taken as a write
    nib_q(4'h9, "unk_cmd");
    nib_q(4'hF, "unk_cmd");
    send_addr(24'h000005, "unk_body");
    for (int k = 0; k < 6; k++) nib_q(4'hF, "unk_body");
    cs_idle();
    do_read(24'h000005, 2);

    // Reset pulse at E11 of a read, chip select held low through it
    nib_q(4'h0, "rr_cmd");
    nib_q(4'h3, "rr_cmd");
    send_addr(24'h000005, "rr_addr");
    nib_q(4'h0, "rr_dummy");
    nib(4'h0);
    check("rr_e9", 32'(sio_o), 32'(model_mem[5][7:4]));
    nib(4'h0);
    check("rr_e10", 32'(sio_o), 32'(model_mem[5][3:0]));
    nib(4'h0);
    check("rr_e11", 32'(sio_o), 32'(model_mem[6][7:4]));
    rst_n = 1'b0;
    #1;
    check("rr_rst_oe", 32'(oe), 32'd0);
    check("rr_rst_sio", 32'(sio_o), 32'd0);
    #1;
    rst_n = 1'b1;
    // First edge after release with CS still low is E0 of this read
    do_read(24'h000005, 2);
    do_read(24'h0003FF, 2);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem.md
IDLI_SQI_MEM -- requirements
Module: idli_sqi_mem

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width of internal storage (2**ADDR_W bytes).
Ports:
REQ-002 SHALL have port i_clk, input, 1, single clock for all logic; SQI bus sampled and driven on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_sqi_cs_n, input, 1, chip select, active-low.
REQ-005 SHALL have port i_sqi_sio, input, 4 (sqi_data_t), nibble from initiator.
REQ-006 SHALL have port o_sqi_sio, output, 4 (sqi_data_t), nibble to initiator.
REQ-007 SHALL have port o_sqi_oe, output, 1, high when o_sqi_sio carries valid read data.

Function
REQ-008 SHALL act as the responder end of one idli SQI link, i.e. one of the SQI_NUM memories (lo or hi nibble), byte-organised storage of 2**ADDR_W bytes, no reset of contents.
REQ-009 SHALL count edge index E from 0 at the first rising edge with i_sqi_cs_n low; all nibbles high-nibble first.
REQ-010 SHALL have states CMD, ADDR, DUMMY, RD, WR, IGNORE; idle state is CMD.
REQ-011 SHALL sample command byte at E0-E1; after E1 go to ADDR for 0x03 (read) or 0x02 (write), else IGNORE.
REQ-012 SHALL sample 24-bit address at E2-E7 (6 nibbles, MSN first); use low ADDR_W bits, ignore upper bits.
REQ-013 Read: after E7 SHALL go to DUMMY; E8-E9 input ignored; after E9 go to RD.
REQ-014 Read: SHALL register o_sqi_sio at E9 with high nibble of mem[A], at E10 low nibble, at E11 high nibble of mem[A+1], and so on; one nibble per edge.
REQ-015 Read: o_sqi_oe SHALL rise at E9 and stay high until CS deassert.
REQ-016 Write: after E7 SHALL go to WR; high nibble sampled on even E, byte committed to mem[A] on odd E (second nibble), A increments after each commit.
REQ-017 Address SHALL increment modulo 2**ADDR_W (sequential mode): 2**ADDR_W-1 wraps to 0 for reads and writes.
REQ-018 IGNORE SHALL drive nothing (o_sqi_oe low), write nothing, until CS deassert.
REQ-019 Any rising edge with i_sqi_cs_n high SHALL return to CMD, drive o_sqi_oe low, discard a half-received write byte; completed bytes stay written.
REQ-020 CS reassert on the edge after deassert SHALL start a new transaction at E0.
REQ-021 Read of a byte written in an earlier transaction SHALL return the written value; write then read of same address in one transaction impossible (single command per CS).
REQ-022 o_sqi_sio SHALL be 0 whenever o_sqi_oe is low.

Reset
REQ-023 While i_rst_n low: state CMD, o_sqi_oe 0, o_sqi_sio 0, address and nibble counters 0; memory contents retained.
REQ-024 Reset mid-transaction SHALL abort it with no partial byte written; after release, the first edge with CS low is E0.

Verification
REQ-025 Write: CS low, nibbles 0,2,0,0,0,0,0,5,A,B,C,D, CS high -> mem[0x005]=0xAB, mem[0x006]=0xCD, o_sqi_oe low throughout.
REQ-026 Read: after REQ-025, nibbles 0,3,0,0,0,0,0,5,x,x -> o_sqi_oe high from E9, o_sqi_sio = A,B,C,D valid after edges E9,E10,E11,E12.
REQ-027 Wrap: mem[0x3FF]=0x12, mem[0x000]=0x34, read address 0xFFF3FF -> o_sqi_sio 1,2,3,4.
REQ-028 Abort: write to 0x010 of nibbles 7,8,9 then CS high -> mem[0x010]=0x78, mem[0x011] unchanged.
REQ-029 Unknown command 0x9F with 12 more nibbles -> o_sqi_oe never high, memory unchanged; next transaction decodes normally.
REQ-030 Reset pulse at E11 of a read -> o_sqi_oe and o_sqi_sio 0 immediately; following read of same address returns unchanged data.
